// File: rtl/timing_sequencer.sv
// timing_sequencer: one-hot T-state generator with stall, early termination, restart, wrap pulse and completed-instruction counter
module timing_sequencer #(
  parameter int NUM_STATES = 7,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  restart,
  input  logic                  hold,
  input  logic                  last,
  output logic [NUM_STATES-1:0] seq,
  output logic [IDX_W-1:0]      step,
  output logic                  wrap,
  output logic [CNT_W-1:0]      instr_count
);
  logic legal;
  logic done;
  // legal means exactly one bit set; done means this edge completes the instruction
  always_comb begin
    legal = (|seq) && ~|(seq & (seq - NUM_STATES'(1)));
    done  = last | seq[NUM_STATES-1];
  end
  // state advance with restart/illegal recovery over hold over completion over stepping
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      seq         <= NUM_STATES'(1);
      step        <= '0;
      wrap        <= 1'b0;
      instr_count <= '0;
    end else if (restart || !legal) begin
      seq  <= NUM_STATES'(1);
      step <= '0;
      wrap <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else if (done) begin
      seq         <= NUM_STATES'(1);
      step        <= '0;
      wrap        <= 1'b1;
      instr_count <= instr_count + CNT_W'(1);
    end else begin
      seq  <= seq << 1;
      step <= step + IDX_W'(1);
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer: directed vectors with a queued scoreboard over four parameterisations
module tb_timing_sequencer;
  typedef struct {
    logic [6:0]  a_seq;
    logic [2:0]  a_step;
    logic        a_wrap;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;
    logic        b_wrap;
    logic [1:0]  c_seq;
    logic        c_wrap;
    logic [3:0]  d_step;
    logic        d_wrap;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic restart, hold, last;
  logic [6:0]  a_seq;
  logic [2:0]  a_step;
  logic        a_wrap;
  logic [15:0] a_cnt;
  logic [6:0]  b_seq;
  logic [2:0]  b_step;
  logic        b_wrap;
  logic [3:0]  b_cnt;
  logic [1:0]  c_seq;
  logic        c_step;
  logic        c_wrap;
  logic [15:0] c_cnt;
  logic [11:0] d_seq;
  logic [3:0]  d_step;
  logic        d_wrap;
  logic [15:0] d_cnt;
  exp_t q[$];
  exp_t e;
  int k = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timing_sequencer u_a (.clk(clk), .clear_n(clear_n), .restart(restart), .hold(hold), .last(last),
    .seq(a_seq), .step(a_step), .wrap(a_wrap), .instr_count(a_cnt));
  timing_sequencer #(.CNT_W(4)) u_b (.clk(clk), .clear_n(clear_n), .restart(1'b0), .hold(1'b0), .last(1'b1),
    .seq(b_seq), .step(b_step), .wrap(b_wrap), .instr_count(b_cnt));
  timing_sequencer #(.NUM_STATES(2), .IDX_W(1)) u_c (.clk(clk), .clear_n(clear_n), .restart(1'b0), .hold(1'b0), .last(1'b0),
    .seq(c_seq), .step(c_step), .wrap(c_wrap), .instr_count(c_cnt));
  timing_sequencer #(.NUM_STATES(12), .IDX_W(4)) u_d (.clk(clk), .clear_n(clear_n), .restart(1'b0), .hold(1'b0), .last(1'b0),
    .seq(d_seq), .step(d_step), .wrap(d_wrap), .instr_count(d_cnt));

  function automatic exp_t mk(input logic [6:0] s, input logic [2:0] st, input logic w, input logic [15:0] c);
    exp_t x;
    x.a_seq  = s;
    x.a_step = st;
    x.a_wrap = w;
    x.a_cnt  = c;
    x.b_cnt  = 4'(k % 16);
    x.b_wrap = k > 0;
    x.c_seq  = (k % 2 == 0) ? 2'b01 : 2'b10;
    x.c_wrap = k > 0 && k % 2 == 0;
    x.d_step = 4'(k % 12);
    x.d_wrap = k > 0 && k % 12 == 0;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic h, input logic l, input logic r,
                     input logic [6:0] s, input logic [2:0] st, input logic w, input logic [15:0] c);
    @(negedge clk);
    clear_n = 1'b1;
    hold = h;
    last = l;
    restart = r;
    k++;
    q.push_back(mk(s, st, w, c));
  endtask

  always @(posedge clk or negedge clear_n) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("a_seq", 32'(a_seq), 32'(e.a_seq));
      chk("a_step", 32'(a_step), 32'(e.a_step));
      chk("a_wrap", 32'(a_wrap), 32'(e.a_wrap));
      chk("a_count", 32'(a_cnt), 32'(e.a_cnt));
      chk("b_count", 32'(b_cnt), 32'(e.b_cnt));
      chk("b_wrap", 32'(b_wrap), 32'(e.b_wrap));
      chk("c_seq", 32'(c_seq), 32'(e.c_seq));
      chk("c_wrap", 32'(c_wrap), 32'(e.c_wrap));
      chk("d_step", 32'(d_step), 32'(e.d_step));
      chk("d_wrap", 32'(d_wrap), 32'(e.d_wrap));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    hold = 1'b0;
    last = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    q.push_back(mk(7'h01, 3'd0, 1'b0, 16'd0));
    for (int i = 1; i <= 14; i++)
      cyc(1'b0, 1'b0, 1'b0, 7'(1 << (i % 7)), 3'(i % 7), i % 7 == 0, 16'(i / 7));
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd2);
    cyc(1'b0, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 16'd2);
    cyc(1'b0, 1'b0, 1'b0, 7'h08, 3'd3, 1'b0, 16'd2);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd3);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd4);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd5);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd6);
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd6);
    cyc(1'b0, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 16'd6);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 7'h04, 3'd2, 1'b0, 16'd6);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h08, 3'd3, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h10, 3'd4, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h20, 3'd5, 1'b0, 16'd7);
    cyc(1'b1, 1'b0, 1'b1, 7'h01, 3'd0, 1'b0, 16'd7);
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd7);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd8);
    cyc(1'b1, 1'b0, 1'b0, 7'h01, 3'd0, 1'b0, 16'd8);
    cyc(1'b1, 1'b0, 1'b0, 7'h01, 3'd0, 1'b0, 16'd8);
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd8);
    cyc(1'b0, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 16'd8);
    cyc(1'b0, 1'b0, 1'b0, 7'h08, 3'd3, 1'b0, 16'd8);
    cyc(1'b0, 1'b0, 1'b0, 7'h10, 3'd4, 1'b0, 16'd8);
    @(negedge clk);
    #2;
    k = 0;
    hold = 1'b0;
    last = 1'b0;
    restart = 1'b0;
    q.push_back(mk(7'h01, 3'd0, 1'b0, 16'd0));
    clear_n = 1'b0;
    @(negedge clk);
    q.push_back(mk(7'h01, 3'd0, 1'b0, 16'd0));
    cyc(1'b0, 1'b0, 1'b0, 7'h02, 3'd1, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 3'd0, 1'b1, 16'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
